// File: rtl/div_result_buffer.sv
// Result buffer behind the combinational divider: captures quotient/flags with rd,
// applies divide-by-zero result semantics and hands entries to writeback via a 2-deep FIFO.
module div_result_buffer #(
  parameter int WIDTH     = 16,
  parameter int RD_WIDTH  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [WIDTH-1:0]     InQuotient,
  input  logic                 InHasRemainder,
  input  logic                 InDivByZero,
  input  logic [RD_WIDTH-1:0]  InRd,
  input  logic                 Flush,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [WIDTH-1:0]     OutData,
  output logic [RD_WIDTH-1:0]  OutRd,
  output logic                 OutHasRemainder,
  output logic                 OutDivByZero,
  output logic [CNT_WIDTH-1:0] DivZeroCount,
  output logic                 DivZeroSticky,
  input  logic                 StatusClear
);

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic [RD_WIDTH-1:0] rd;
    logic                hasrem;
    logic                divzero;
  } entry_t;

  entry_t               mem_q [2];
  entry_t               mem_d [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0] dz_cnt_q, dz_cnt_d;
  logic                 dz_sticky_q, dz_sticky_d;

  logic   push;
  logic   pop;
  entry_t head;
  entry_t new_entry;

  // Both handshakes look only at registered occupancy, so InReady never depends on OutReady.
  assign InReady  = (count_q != 2'd2);
  assign OutValid = (count_q != 2'd0);
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady & ~Flush;

  assign new_entry.data    = InDivByZero ? {WIDTH{1'b1}} : InQuotient;
  assign new_entry.rd      = InRd;
  assign new_entry.hasrem  = InHasRemainder;
  assign new_entry.divzero = InDivByZero;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    dz_cnt_d    = dz_cnt_q;
    dz_sticky_d = dz_sticky_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Flush blocks push, so the write pointer holds and the read pointer catches up to it.
    if (Flush) begin
      count_d  = 2'd0;
      rd_ptr_d = wr_ptr_q;
    end

    if (StatusClear) begin
      dz_cnt_d    = '0;
      dz_sticky_d = 1'b0;
    end else if (push && InDivByZero) begin
      dz_sticky_d = 1'b1;
      if (dz_cnt_q != {CNT_WIDTH{1'b1}}) begin
        dz_cnt_d = dz_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: entry storage is reset too, so Out* fields read as zero straight after reset.
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      dz_cnt_q    <= '0;
      dz_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dz_cnt_q    <= dz_cnt_d;
      dz_sticky_q <= dz_sticky_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign OutData         = head.data;
  assign OutRd           = head.rd;
  assign OutHasRemainder = head.hasrem;
  assign OutDivByZero    = head.divzero;
  assign DivZeroCount    = dz_cnt_q;
  assign DivZeroSticky   = dz_sticky_q;

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Sequential stage directly downstream of the combinational Division unit in the ALU path.
- Captures each Division result (Quotient, HasRemainder, DivByZero) with its destination register index.
- Applies RISC-V divide-by-zero result semantics and delivers results to writeback through a 2-entry valid/ready FIFO.
- Keeps a saturating divide-by-zero event counter and a sticky status flag for the trap/CSR logic.

Parameters:
- WIDTH, 16, data width of quotient and output data; matches Division #(16).
- RD_WIDTH, 4, width of destination register index.
- CNT_WIDTH, 8, width of the divide-by-zero event counter.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  upstream holds a valid Division result this cycle.
- InReady  output  1  buffer can accept an entry this cycle.
- InQuotient  input  WIDTH  Quotient from Division.
- InHasRemainder  input  1  HasRemainder from Division.
- InDivByZero  input  1  DivByZero from Division.
- InRd  input  RD_WIDTH  destination register index of the divide instruction.
- Flush  input  1  synchronous pipeline flush; discards buffered entries.
- OutValid  output  1  head entry valid.
- OutReady  input  1  writeback accepts head entry.
- OutData  output  WIDTH  result to write back.
- OutRd  output  RD_WIDTH  destination index of head entry.
- OutHasRemainder  output  1  HasRemainder of head entry.
- OutDivByZero  output  1  DivByZero of head entry.
- DivZeroCount  output  CNT_WIDTH  saturating count of accepted divide-by-zero entries.
- DivZeroSticky  output  1  set on any accepted divide-by-zero; cleared only by StatusClear or Reset.
- StatusClear  input  1  clears DivZeroCount and DivZeroSticky.

Behaviour:
- Storage: 2 entries, each {data, rd, hasrem, divzero}; read pointer, write pointer (1 bit each), Count in 0..2.
- Reset (synchronous, active-high): Count=0, pointers=0, DivZeroCount=0, DivZeroSticky=0. Outputs after reset: OutValid=0, InReady=1. OutData/OutRd/OutHasRemainder/OutDivByZero=0 (entry storage cleared).
- InReady = (Count != 2). It depends only on registered state, with no combinational path from OutReady.
- OutValid = (Count != 0). Out* fields are driven from the entry at the read pointer.
- Push = InValid & InReady & ~Flush.
  - Entry written at the write pointer; write pointer toggles.
  - Stored data = all ones ({WIDTH{1'b1}}) when InDivByZero=1, else InQuotient.
  - hasrem, divzero and rd are stored unmodified.
- Pop = OutValid & OutReady & ~Flush; read pointer toggles.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (legal only at Count=1): unchanged.
- Latency: an entry pushed in cycle N is visible on Out* with OutValid=1 in cycle N+1. Throughput is 1 per cycle when OutReady is held high.
- Ordering: strict FIFO. When Out* is stalled (OutValid=1, OutReady=0), Out* stays stable until popped.
- Full (Count=2): InReady=0; InValid is ignored and no entry is written. A pop in the same cycle does not enable a push; InReady rises the next cycle.
- Empty (Count=0): OutReady is ignored and there is no pointer change.
- Flush:
  - Next cycle: Count=0 and read pointer = write pointer.
  - A same-cycle push and pop are both discarded.
  - Flush does not affect DivZeroCount or DivZeroSticky.
- Divide-by-zero status:
  - On a push with InDivByZero=1, DivZeroSticky is set to 1.
  - On the same push, DivZeroCount increments, saturating at 2^CNT_WIDTH-1 with no wrap.
  - StatusClear together with such a push: the clear wins, giving a count of 0 and sticky of 0.
  - Flushed (discarded) entries never update the status.
- Reset asserted mid-transfer overrides Flush, push, pop and StatusClear.

Test Plan:
- Reset then idle -> OutValid=0, InReady=1, DivZeroCount=0, DivZeroSticky=0, Out* fields 0.
- Push {Q=2, rem=1, dz=0, rd=3} with OutReady=1 -> next cycle OutValid=1, OutData=16'd2, OutHasRemainder=1, OutRd=3; following cycle OutValid=0.
- Push {Q=0, dz=1, rd=5} -> OutData=16'hFFFF, OutDivByZero=1, DivZeroSticky=1, DivZeroCount=1; then StatusClear -> both 0.
- OutReady=0, push results 6 (rd=1), 4 (rd=2), then 3 (rd=4):
  - Required: InReady=0 after the second push; the third push is not accepted.
  - Then OutReady=1: outputs 6 then 4 in order.
  - After re-presenting 3, output 3.
- Count=1, simultaneous push (Q=9) and pop -> Count stays 1; next head OutData=9; back-to-back stream of 10 results with OutReady=1 sustains 1 result per cycle.
- Count=2, assert Flush with InValid=1 -> next cycle OutValid=0, InReady=1, DivZeroCount unchanged; 300 divide-by-zero pushes -> DivZeroCount saturates at 255.
